// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller: ALU op codes, control width and FSM states.
package alu_pkg;

    localparam int CTRL_WIDTH = 3;

    localparam logic [CTRL_WIDTH-1:0] ALU_ADD = 3'd0;
    localparam logic [CTRL_WIDTH-1:0] ALU_SUB = 3'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or after i_ptr, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_valid
);

    int w_pos;

    // Scan farthest-to-nearest so the requester closest to the pointer wins.
    always_comb begin
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_pos         = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            if (i_req[w_pos]) begin
                o_grant_idx   = IDX_W'(w_pos);
                o_grant_valid = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign o_grant[gi] = o_grant_valid && (o_grant_idx == IDX_W'(gi));
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between NUM_REQ requesters with round-robin arbitration
// and a registered request/response handshake (IDLE -> EXEC -> RESP).
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REQ    = 2,
    parameter  int CTRL_WIDTH = alu_pkg::CTRL_WIDTH,
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_op1,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_op2,
    input  logic [NUM_REQ-1:0][CTRL_WIDTH-1:0]   req_ctrl,
    output logic [NUM_REQ-1:0]                   resp_valid,
    input  logic [NUM_REQ-1:0]                   resp_ready,
    output logic [DATA_WIDTH-1:0]                resp_data,
    output logic                                 resp_eq,
    output logic [DATA_WIDTH-1:0]                alu_op1,
    output logic [DATA_WIDTH-1:0]                alu_op2,
    output logic [CTRL_WIDTH-1:0]                alu_ctrl,
    input  logic [DATA_WIDTH-1:0]                alu_out,
    input  logic                                 alu_eq,
    output logic                                 busy
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [IDX_W-1:0]       r_owner;
    logic [DATA_WIDTH-1:0]  r_op1;
    logic [DATA_WIDTH-1:0]  r_op2;
    logic [CTRL_WIDTH-1:0]  r_ctrl;
    logic [DATA_WIDTH-1:0]  r_resp_data;
    logic                   r_resp_eq;

    logic [NUM_REQ-1:0]     w_grant_oh;
    logic [IDX_W-1:0]       w_grant_idx;
    logic                   w_grant_any;
    logic [NUM_REQ-1:0]     w_owner_oh;
    logic                   w_accept;
    logic                   w_resp_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req         (req_valid),
        .i_ptr         (r_rr_ptr),
        .o_grant       (w_grant_oh),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_any)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_owner
        assign w_owner_oh[gi] = (r_owner == IDX_W'(gi));
    end

    assign w_accept    = (r_state == IDLE) && w_grant_any;
    assign w_resp_done = (r_state == RESP) && resp_ready[r_owner];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant_any) w_state_next = EXEC;
            EXEC:    w_state_next = RESP;
            RESP:    if (resp_ready[r_owner]) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // req_ready is masked during reset so no handshake can be observed on a reset edge.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        busy       = 1'b0;
        case (r_state)
            IDLE:    if (rst_n) req_ready = w_grant_oh;
            EXEC:    busy = 1'b1;
            RESP: begin
                busy       = 1'b1;
                resp_valid = w_owner_oh;
            end
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_ctrl      <= '0;
            r_resp_data <= '0;
            r_resp_eq   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op1   <= req_op1[w_grant_idx];
                r_op2   <= req_op2[w_grant_idx];
                r_ctrl  <= req_ctrl[w_grant_idx];
                r_owner <= w_grant_idx;
            end
            if (r_state == EXEC) begin
                r_resp_data <= alu_out;
                r_resp_eq   <= alu_eq;
            end
            if (w_resp_done) begin
                r_rr_ptr <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
            end
        end
    end

    assign alu_op1   = r_op1;
    assign alu_op2   = r_op2;
    assign alu_ctrl  = r_ctrl;
    assign resp_data = r_resp_data;
    assign resp_eq   = r_resp_eq;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios followed by random traffic, checked against a
// transaction-level model of arbitration order, latency and ALU results.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int NR = 2;
    localparam int CW = 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NR-1:0]            req_valid;
    logic [NR-1:0]            req_ready;
    logic [NR-1:0][DW-1:0]    req_op1;
    logic [NR-1:0][DW-1:0]    req_op2;
    logic [NR-1:0][CW-1:0]    req_ctrl;
    logic [NR-1:0]            resp_valid;
    logic [NR-1:0]            resp_ready;
    logic [DW-1:0]            resp_data;
    logic                     resp_eq;
    logic [DW-1:0]            alu_op1;
    logic [DW-1:0]            alu_op2;
    logic [CW-1:0]            alu_ctrl;
    logic [DW-1:0]            alu_out;
    logic                     alu_eq;
    logic                     busy;

    alu_share_ctrl #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .CTRL_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_ctrl   (req_ctrl),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_eq    (resp_eq),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_ctrl   (alu_ctrl),
        .alu_out    (alu_out),
        .alu_eq     (alu_eq),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the external ALU.
    always_comb begin
        alu_out = '0;
        if (alu_ctrl == ALU_ADD) alu_out = alu_op1 + alu_op2;
        else if (alu_ctrl == ALU_SUB) alu_out = alu_op1 + ~alu_op2 + 32'd1;
        alu_eq = (alu_op1 == alu_op2);
    end

    int n_cmp = 0;
    int n_mis = 0;

    // Transaction-level model state.
    int            phase = -1;   // -1 idle, else cycles since accept
    int            own = 0;
    int            ptr = 0;
    int            last_grant = -1;
    int            n_acc = 0;
    int            n_done = 0;
    bit            after_rst = 1'b0;
    logic [DW-1:0] exp_op1, exp_op2, exp_res;
    logic [CW-1:0] exp_ctrl;
    logic          exp_eq;

    function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [CW-1:0] c);
        if (c == ALU_ADD) return a + b;
        if (c == ALU_SUB) return a - b;
        return '0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: check outputs against the model, predict the edge, advance.
    task automatic step();
        int            g;
        bit            acc;
        logic [NR-1:0] exp_rdy;
        logic [NR-1:0] exp_rv;
        #1;
        g = -1;
        acc = 1'b0;
        exp_rdy = '0;
        exp_rv = '0;
        if (rst_n && phase < 0) begin
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && req_valid[(ptr + k) % NR]) g = (ptr + k) % NR;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        if (phase >= 2) exp_rv[own] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("resp_valid", 64'(resp_valid), 64'(exp_rv));
        check("busy", 64'(busy), 64'(phase >= 0));
        if (phase >= 1) begin
            check("alu_op1", 64'(alu_op1), 64'(exp_op1));
            check("alu_op2", 64'(alu_op2), 64'(exp_op2));
            check("alu_ctrl", 64'(alu_ctrl), 64'(exp_ctrl));
        end
        if (phase >= 2) begin
            check("resp_data", 64'(resp_data), 64'(exp_res));
            check("resp_eq", 64'(resp_eq), 64'(exp_eq));
        end
        if (after_rst) begin
            check("rst_resp_data", 64'(resp_data), 64'd0);
            check("rst_resp_eq", 64'(resp_eq), 64'd0);
            check("rst_alu_op1", 64'(alu_op1), 64'd0);
            check("rst_alu_op2", 64'(alu_op2), 64'd0);
            check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
            after_rst = 1'b0;
        end
        if (!rst_n) begin
            phase = -1;
            ptr = 0;
            after_rst = 1'b1;
        end else if (phase < 0) begin
            if (g >= 0) begin
                acc = 1'b1;
                phase = 1;
                own = g;
                last_grant = g;
                n_acc++;
                exp_op1 = req_op1[g];
                exp_op2 = req_op2[g];
                exp_ctrl = req_ctrl[g];
                exp_res = ref_alu(exp_op1, exp_op2, exp_ctrl);
                exp_eq = (exp_op1 == exp_op2);
            end
        end else if (phase == 1) begin
            phase = 2;
        end else if (resp_ready[own]) begin
            phase = -1;
            ptr = (own + 1) % NR;
            n_done++;
        end
        @(negedge clk);
        if (acc) begin
            req_valid[g] = 1'b0;
            req_op1[g] = $urandom;  // post-accept operand changes must not matter
            req_op2[g] = $urandom;
        end
    endtask

    task automatic set_req(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [CW-1:0] c);
        req_valid[r] = 1'b1;
        req_op1[r] = a;
        req_op2[r] = b;
        req_ctrl[r] = c;
    endtask

    initial begin
        int            grants[$];
        int            acc0;
        int            done0;
        int            cval;
        logic [DW-1:0] held;

        rst_n = 1'b0;
        req_valid = '0;
        req_op1 = '0;
        req_op2 = '0;
        req_ctrl = '0;
        resp_ready = '0;
        repeat (2) @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        resp_ready = '1;

        // Single add on requester 0.
        set_req(0, 32'd5, 32'd3, ALU_ADD);
        #1;
        check("t1_ready_c0", 64'(req_ready), 64'b01);
        step();
        step();
        #1;
        check("t1_resp_valid_c2", 64'(resp_valid), 64'b01);
        check("t1_resp_data", 64'(resp_data), 64'd8);
        check("t1_resp_eq", 64'(resp_eq), 64'd0);
        step();

        // Subtract equal operands on requester 1.
        set_req(1, 32'h2A, 32'h2A, ALU_SUB);
        step();
        step();
        #1;
        check("t2_resp_valid", 64'(resp_valid), 64'b10);
        check("t2_resp_data", 64'(resp_data), 64'd0);
        check("t2_resp_eq", 64'(resp_eq), 64'd1);
        step();

        // Both requesters continuously valid.
        acc0 = n_acc;
        for (int i = 0; i < 12; i++) begin
            for (int r = 0; r < NR; r++) begin
                if (!req_valid[r]) set_req(r, $urandom, $urandom, ALU_ADD);
            end
            if (n_acc == 0) ;
            step();
            if (n_acc != acc0 + grants.size()) grants.push_back(last_grant);
        end
        req_valid = '0;
        check("fair_count", 64'(n_acc - acc0), 64'd4);
        for (int i = 0; i < grants.size(); i++) begin
            check("fair_order", 64'(grants[i]), 64'(i % 2));
        end

        // Back-pressure on requester 0 while requester 1 waits.
        resp_ready = 2'b10;
        set_req(0, 32'h1234, 32'h0FF, ALU_SUB);
        step();
        set_req(1, 32'd11, 32'd22, ALU_ADD);
        step();
        held = exp_res;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_ready1_low", 64'(req_ready[1]), 64'd0);
            check("bp_busy", 64'(busy), 64'd1);
            check("bp_data_held", 64'(resp_data), 64'(held));
            step();
        end
        resp_ready = '1;
        step();
        step();
        check("bp_next_grant", 64'(last_grant), 64'd1);
        step();
        step();

        // Unsupported ctrl code gives zero.
        set_req(0, 32'd7, 32'd3, 3'd5);
        step();
        step();
        #1;
        check("t5_resp_data", 64'(resp_data), 64'd0);
        check("t5_resp_eq", 64'(resp_eq), 64'd0);
        step();
        check("t5_done_busy", 64'(busy), 64'd0);

        // Reset while in EXEC drops the operation.
        set_req(0, 32'd100, 32'd1, ALU_ADD);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("rst_state_idle", 64'(busy), 64'd0);
        check("rst_no_resp", 64'(resp_valid), 64'd0);
        for (int i = 0; i < 4; i++) step();

        // Random traffic.
        done0 = n_done;
        for (int i = 0; i < 800; i++) begin
            for (int r = 0; r < NR; r++) begin
                if (!req_valid[r]) begin
                    req_op1[r] = $urandom;
                    req_op2[r] = ($urandom_range(0, 3) == 0) ? req_op1[r] : $urandom;
                    cval = $urandom_range(0, 3);
                    req_ctrl[r] = (cval < 2) ? CW'(cval) : CW'($urandom_range(2, 7));
                    if ($urandom_range(0, 9) < 4) req_valid[r] = 1'b1;
                end
            end
            for (int r = 0; r < NR; r++) resp_ready[r] = ($urandom_range(0, 9) < 7);
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;
        req_valid = '0;
        resp_ready = '1;
        for (int i = 0; i < 6; i++) step();
        check("rand_progress", 64'(n_done - done0 > 50), 64'd1);
        check("rand_drained", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Multi-cycle controller that shares one combinational ALU between NUM_REQ requesters (e.g. execute stage and branch-compare unit).
- Round-robin arbitration, valid/ready on both request and response sides, registered operands and result.
- Drives the ALU's operand and control inputs; captures the ALU result and eq flag.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the ALU instance.
- NUM_REQ, 2, number of requesters; legal range 2..4.
- CTRL_WIDTH, 3, ALU control width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op1  in  NUM_REQ x DATA_WIDTH  operand 1 per requester.
- req_op2  in  NUM_REQ x DATA_WIDTH  operand 2 per requester.
- req_ctrl  in  NUM_REQ x CTRL_WIDTH  ALU op per requester (0 add, 1 sub, others give zero).
- resp_valid  out  NUM_REQ  result valid, routed to the owning requester.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_data  out  DATA_WIDTH  registered ALU result, shared bus.
- resp_eq  out  1  registered ALU eq flag.
- alu_op1  out  DATA_WIDTH  to ALU aluop1.
- alu_op2  out  DATA_WIDTH  to ALU aluop2.
- alu_ctrl  out  CTRL_WIDTH  to ALU aluctrl.
- alu_out  in  DATA_WIDTH  from ALU.
- alu_eq  in  1  from ALU.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (rst_n low at a clock edge):
  - state goes to IDLE and the round-robin pointer rr_ptr goes to 0.
  - req_ready, resp_valid, resp_data, resp_eq, alu_op1/op2/ctrl and busy all go to 0.
  - the owner register goes to 0.
- Reset mid-transaction: the in-flight operation is dropped silently and no response is issued.
- IDLE:
  - grant is the first requester with req_valid high, searching from rr_ptr upward with wrap-around.
  - req_ready[grant] is combinationally high in IDLE only; all other bits are 0.
  - on the edge where req_valid[g] and req_ready[g] are both high: latch op1, op2, ctrl and owner=g, then go to EXEC.
  - with no valid requests, the FSM stays in IDLE.
- EXEC:
  - alu_op1/op2/ctrl are driven from the latched registers; they are held stable from EXEC through RESP and keep their last value in IDLE.
  - at the end of EXEC, capture alu_out into resp_data and alu_eq into resp_eq, then go to RESP.
- RESP:
  - resp_valid[owner] is high; other resp_valid bits are 0.
  - resp_data and resp_eq are held stable until the handshake.
  - on resp_ready[owner] high, go to IDLE and set rr_ptr = (owner+1) mod NUM_REQ.
  - resp_ready on non-owner bits is ignored.
- Latency:
  - accept edge is cycle 0; resp_valid is high in cycle 2.
  - minimum 3 cycles per operation, with no overlap.
- Back-pressure: while resp_ready is held low, the FSM stays in RESP indefinitely and accepts no request.
- Fairness:
  - with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.
  - a lone requester is served every 3 cycles.
- Arithmetic: none in this block; ctrl passes through unchecked, and width and overflow rules belong to the ALU.
- Protocol:
  - a requester holds its valid and operands until its ready is seen.
  - operands sampled only at the accept edge; later changes have no effect.

Decomposition:
- Shared package alu_pkg:
  - ALU op constants ALU_ADD=3'd0, ALU_SUB=3'd1.
  - CTRL_WIDTH constant.
  - FSM state enum typedef (IDLE, EXEC, RESP).
- Sub-module rr_arbiter:
  - inputs: request vector and pointer.
  - outputs: one-hot grant and encoded index.
  - purely combinational; reusable for future shared resources.

Test Plan:
- Reset then single request: req0 op1=5, op2=3, ctrl=0 -> req_ready[0] high in cycle 0, resp_valid[0] high in cycle 2, resp_data=8, resp_eq=0.
- Subtract equal operands: req1 op1=0x2A, op2=0x2A, ctrl=1 -> resp_valid[1] high, resp_data=0, resp_eq=1; resp_valid[0] stays 0.
- Both requesters valid continuously, ctrl=0, resp_ready=1 -> grant order 0,1,0,1, one response every 3 cycles, no starvation.
- Back-pressure: hold resp_ready[0]=0 for 10 cycles with req1 valid -> resp_data held, req_ready[1] stays 0 and busy=1 throughout; after resp_ready[0]=1, req1 is granted next.
- Illegal ctrl=3'd5 with op1=7 -> resp_data=0, resp_eq=0, normal handshake completes.
- rst_n low during EXEC -> next cycle state is IDLE with all outputs 0, and no resp_valid is ever raised for the dropped op.
